// File: rtl/cpu_tx_mailbox.sv
// Memory-mapped transmit mailbox: CPU stores words into a FIFO via an I/O window,
// the host drains them first-word-fall-through through the pipe-out read strobe.
module cpu_tx_mailbox #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] w_data,
    output logic        io_sel,
    output logic [31:0] io_r_data,
    input  logic        pipe_read,
    output logic [31:0] pipe_data,
    output logic        blk_ready,
    output logic        empty,
    output logic        full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WAW = 30;

    localparam logic [WAW-1:0] BASE_WORD = BASE_ADDR[31:2];
    localparam logic [WAW-1:0] OFF_DATA  = WAW'(0);
    localparam logic [WAW-1:0] OFF_STAT  = WAW'(1);
    localparam logic [WAW-1:0] OFF_CTRL  = WAW'(2);

    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           underflow_q, underflow_d;
    logic [7:0]     ovf_cnt_q, ovf_cnt_d;
    logic [31:0]    io_r_data_q, io_r_data_d;
    logic           blk_ready_q, blk_ready_d;

    logic [WAW-1:0] word_off;
    logic           flush, clr_sticky, push_req, push_ok, pop_ok;
    logic [31:0]    status;
    logic           unused_addr_bits;

    // Window decode ignores the byte-lane bits so misaligned accesses hit the aligned word.
    assign word_off         = mem_addr[31:2] - BASE_WORD;
    assign io_sel           = (mem_addr[31:2] >= BASE_WORD) && (word_off < WAW'(3));
    assign unused_addr_bits = ^mem_addr[1:0];

    assign empty     = (count_q == CW'(0));
    assign full      = (count_q == CW'(DEPTH));
    assign pipe_data = empty ? 32'h0 : mem_q[rd_ptr_q];
    assign io_r_data = io_r_data_q;
    assign blk_ready = blk_ready_q;

    assign status = {ovf_cnt_q, 5'b0, underflow_q, empty, full, 16'(count_q)};

    assign flush      = wr_en && io_sel && (word_off == OFF_CTRL) && w_data[0];
    assign clr_sticky = wr_en && io_sel && (word_off == OFF_CTRL) && w_data[1];
    assign push_req   = wr_en && io_sel && (word_off == OFF_DATA) && !flush;
    assign pop_ok     = pipe_read && !empty && !flush;
    assign push_ok    = push_req && (!full || pop_ok);

    // Next-state for pointers, count, stickies and registered outputs.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        ovf_cnt_d   = ovf_cnt_q;
        io_r_data_d = io_r_data_q;
        blk_ready_d = (count_q >= CW'(BLOCK_WORDS));

        if (io_sel && !wr_en) begin
            io_r_data_d = (word_off == OFF_STAT) ? status : 32'h0;
        end

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            underflow_d = 1'b0;
            ovf_cnt_d   = 8'h0;
        end else begin
            if (clr_sticky) begin
                underflow_d = 1'b0;
                ovf_cnt_d   = 8'h0;
            end
            // A fresh underflow in the same cycle as a sticky clear is kept.
            if (pipe_read && empty) begin
                underflow_d = 1'b1;
            end
            if (push_req && !push_ok && (ovf_cnt_q != 8'hFF)) begin
                ovf_cnt_d = ovf_cnt_q + 8'h1;
            end
            if (push_ok) begin
                wr_ptr_d = AW'(wr_ptr_q + AW'(1));
            end
            if (pop_ok) begin
                rd_ptr_d = AW'(rd_ptr_q + AW'(1));
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = CW'(count_q + CW'(1));
                2'b01:   count_d = CW'(count_q - CW'(1));
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            ovf_cnt_q   <= 8'h0;
            io_r_data_q <= 32'h0;
            blk_ready_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            ovf_cnt_q   <= ovf_cnt_d;
            io_r_data_q <= io_r_data_d;
            blk_ready_q <= blk_ready_d;
        end
    end

    // Storage needs no reset; count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

endmodule

// File: tb/tb_cpu_tx_mailbox.sv
// Randomized self-checking bench for cpu_tx_mailbox against a queue-based mailbox model.
module tb_cpu_tx_mailbox;

    localparam logic [31:0] BASE  = 32'hFFFF_FF00;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned BLK   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] w_data = 32'h0;
    logic        pipe_read = 1'b0;
    logic        io_sel;
    logic [31:0] io_r_data;
    logic [31:0] pipe_data;
    logic        blk_ready;
    logic        empty;
    logic        full;

    cpu_tx_mailbox #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .BLOCK_WORDS(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .mem_addr(mem_addr), .w_data(w_data),
        .io_sel(io_sel), .io_r_data(io_r_data), .pipe_read(pipe_read),
        .pipe_data(pipe_data), .blk_ready(blk_ready), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] q[$];
    logic        m_unf;
    logic [7:0]  m_ovf;
    logic [31:0] m_rdata;
    logic        m_blk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_status();
        int unsigned cnt = q.size();
        return {m_ovf, 5'b0, m_unf, (cnt == 0), (cnt == DEPTH), 16'(cnt)};
    endfunction

    task automatic check_outputs();
        check("pipe_data", pipe_data, (q.size() != 0) ? q[0] : 32'h0);
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("blk_ready", 32'(blk_ready), 32'(m_blk));
        check("io_r_data", io_r_data, m_rdata);
    endtask

    // One bus cycle: drive, check decode, clock, update model, check outputs.
    task automatic step(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic rd);
        logic        sel;
        int unsigned off;
        int unsigned cnt;
        logic        pop_ok;
        logic        flush;
        wr_en = wr; mem_addr = addr; w_data = data; pipe_read = rd;
        sel = (addr >= BASE) && ((addr - BASE) < 32'd12);
        off = sel ? 32'((addr - BASE) >> 2) : 32'd99;
        #1;
        check("io_sel", 32'(io_sel), 32'(sel));
        cnt = q.size();
        if (sel && !wr) m_rdata = (off == 1) ? model_status() : 32'h0;
        m_blk = (cnt >= BLK);
        flush = wr && (off == 2) && data[0];
        if (flush) begin
            q.delete();
            m_unf = 1'b0;
            m_ovf = 8'h0;
        end else begin
            if (wr && (off == 2) && data[1]) begin
                m_unf = 1'b0;
                m_ovf = 8'h0;
            end
            pop_ok = rd && (cnt > 0);
            if (rd && cnt == 0) m_unf = 1'b1;
            if (pop_ok) void'(q.pop_front());
            if (wr && off == 0) begin
                if (cnt < DEPTH || pop_ok) q.push_back(data);
                else if (m_ovf != 8'hFF) m_ovf = m_ovf + 8'h1;
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; pipe_read = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0; pipe_read = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        m_unf = 1'b0; m_ovf = 8'h0; m_rdata = 32'h0; m_blk = 1'b0;
        check_outputs();
        rst_n = 1'b1;
    endtask

    task automatic push(input logic [31:0] d);
        step(1'b1, BASE, d, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, BASE, 32'h0, 1'b1);
    endtask

    task automatic read_status(input string tag, input logic [31:0] exp);
        step(1'b0, BASE + 32'd4, 32'h0, 1'b0);
        check(tag, io_r_data, exp);
    endtask

    initial begin
        logic [31:0] last;
        logic [31:0] a;
        int unsigned r;
        m_unf = 1'b0; m_ovf = 8'h0; m_rdata = 32'h0; m_blk = 1'b0;
        @(posedge clk);
        do_reset();
        read_status("status_after_reset", 32'h0002_0000);

        // Three words in, three out in order
        for (int i = 1; i <= 3; i++) push(32'h1111_0000 + 32'(i));
        read_status("status_cnt3", 32'h0000_0003);
        check("head_first", pipe_data, 32'h1111_0001);
        for (int i = 0; i < 3; i++) pop();
        check("empty_after_drain", 32'(empty), 32'h1);

        // Overflow on the 17th push
        for (int i = 0; i < 17; i++) push($urandom);
        read_status("status_overflow", 32'h0101_0010);

        // Full with simultaneous push and pop
        step(1'b1, BASE, 32'hAAAA_5555, 1'b1);
        read_status("status_full_pushpop", 32'h0101_0010);
        last = 32'h0;
        for (int i = 0; i < 16; i++) begin
            last = pipe_data;
            pop();
        end
        check("last_word_out", last, 32'hAAAA_5555);

        // Underflow sticky and its clear
        pop();
        check("underflow_pipe_data", pipe_data, 32'h0);
        read_status("status_underflow", 32'h0106_0000);
        step(1'b1, BASE + 32'd8, 32'h2, 1'b0);
        read_status("status_cleared", 32'h0002_0000);

        // blk_ready timing (checked each cycle through the model)
        for (int i = 0; i < 8; i++) push($urandom);
        step(1'b0, BASE + 32'd20, 32'h0, 1'b0);
        check("blk_ready_high", 32'(blk_ready), 32'h1);
        pop();
        step(1'b0, BASE + 32'd20, 32'h0, 1'b0);
        check("blk_ready_low", 32'(blk_ready), 32'h0);

        // Flush with a concurrent pop, then a push right after
        for (int i = 0; i < 5; i++) push($urandom);
        step(1'b1, BASE + 32'd8, 32'h1, 1'b1);
        read_status("status_flushed", 32'h0002_0000);
        push(32'hDEAD_0000);
        check("push_after_flush", pipe_data, 32'hDEAD_0000);
        pop();

        // Empty FIFO, simultaneous push and pop: no bypass, underflow set
        step(1'b1, BASE, 32'h1234_5678, 1'b1);
        read_status("status_empty_pushpop", 32'h0004_0001);
        step(1'b1, BASE + 32'd10, 32'h3, 1'b0);

        // Wrap test: 40 interleaved pushes and pops
        for (int i = 0; i < 40; i++) begin
            push($urandom);
            if (i % 3 != 0) pop();
        end
        while (q.size() != 0) pop();

        // Random bus traffic across the window, misaligned lanes and outside addresses
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r < 11) a = BASE + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 3));
            else if (r < 13) a = BASE + 32'd12 + 32'($urandom_range(0, 7));
            else a = BASE - 32'd4 + 32'($urandom_range(0, 3));
            if (a[3:2] == 2'b10 && $urandom_range(0, 7) != 0) a = BASE;
            step(1'($urandom_range(0, 2) != 0), a, $urandom, 1'($urandom_range(0, 2) == 0));
        end

        // Reset mid-stream discards queued data
        for (int i = 0; i < 6; i++) push($urandom);
        do_reset();
        read_status("status_after_midreset", 32'h0002_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
